// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// The ID type names the requester that owns each outstanding transaction.
package mem_bus_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side (instr + data) and memory-side req/gnt/valid signals of the arbiter.
// slave: the arbiter's view; master: the core and memory environment's view.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            instr_req;
    logic [AW-1:0]   instr_addr;
    logic            instr_gnt;
    logic [DW-1:0]   instr_rdata;
    logic            instr_valid;
    logic            instr_err;

    logic            data_req;
    logic            data_wr;
    logic [AW-1:0]   data_addr;
    logic [DW-1:0]   data_wdata;
    logic [DW/8-1:0] data_be;
    logic            data_gnt;
    logic [DW-1:0]   data_rdata;
    logic            data_valid;
    logic            data_error;

    logic            mem_req;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic [DW-1:0]   mem_rdata;
    logic            mem_valid;
    logic            mem_err;

    logic            spurious_rsp;

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rdata, instr_valid, instr_err,
        input  data_req, data_wr, data_addr, data_wdata, data_be,
        output data_gnt, data_rdata, data_valid, data_error,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rdata, mem_valid, mem_err,
        output spurious_rsp
    );

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rdata, instr_valid, instr_err,
        output data_req, data_wr, data_addr, data_wdata, data_be,
        input  data_gnt, data_rdata, data_valid, data_error,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rdata, mem_valid, mem_err,
        input  spurious_rsp
    );
endinterface

// File: rtl/mem_bus_arbiter_id_fifo.sv
// Small synchronous FIFO holding requester IDs of outstanding transactions.
// Push while full and pop while empty are ignored.
module mem_bus_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and LSU; holds a stalled winner
// until granted and routes in-order responses back via an ID FIFO.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    logic        active_q, en;
    lock_state_e state_q, state_d;
    req_id_e     lock_id_q, lock_id_d, last_q, last_d, win;
    logic        fifo_full, fifo_empty, any_req, mem_req, accept, pop;
    logic [0:0]  head;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [BW-1:0] be_mux;

    // Outputs stay quiet during reset and the cycle in which reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) active_q <= 1'b0;
        else          active_q <= 1'b1;
    end
    assign en = active_q && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= UNLOCKED;
            lock_id_q <= REQ_INSTR;
            last_q    <= REQ_INSTR;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
        end
    end

    assign any_req = bus.instr_req || bus.data_req;
    assign mem_req = en && any_req && !fifo_full;
    assign accept  = mem_req && bus.mem_gnt;

    always_comb begin
        win       = REQ_INSTR;
        state_d   = UNLOCKED;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        // A locked winner that retracts its request loses the lock to normal arbitration.
        if (state_q == LOCKED && ((lock_id_q == REQ_DATA) ? bus.data_req : bus.instr_req))
            win = lock_id_q;
        else if (bus.instr_req && bus.data_req)
            win = (ARB_MODE == ARB_RR && last_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
        else if (bus.data_req)
            win = REQ_DATA;
        if (mem_req && !bus.mem_gnt) begin
            state_d   = LOCKED;
            lock_id_d = win;
        end
        if (accept) last_d = win;
    end

    assign addr_mux  = (win == REQ_DATA) ? bus.data_addr  : bus.instr_addr;
    assign wdata_mux = (win == REQ_DATA) ? bus.data_wdata : '0;
    assign be_mux    = (win == REQ_DATA) ? bus.data_be    : '1;

    assign bus.mem_req   = mem_req;
    assign bus.mem_wr    = en && win == REQ_DATA && bus.data_wr;
    assign bus.mem_addr  = en ? addr_mux  : '0;
    assign bus.mem_wdata = en ? wdata_mux : '0;
    assign bus.mem_be    = en ? be_mux    : '0;
    assign bus.instr_gnt = accept && win == REQ_INSTR;
    assign bus.data_gnt  = accept && win == REQ_DATA;

    mem_bus_id_fifo #(
        .DEPTH(MAX_OUTST),
        .WIDTH(1)
    ) u_id_fifo (
        .clk    (clk),
        .rst_n  (reset_n),
        .push_i (accept),
        .din_i  (1'(win)),
        .pop_i  (pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (head)
    );

    assign pop              = en && bus.mem_valid && !fifo_empty;
    assign bus.spurious_rsp = en && bus.mem_valid && fifo_empty;
    assign bus.instr_valid  = pop && req_id_e'(head) == REQ_INSTR;
    assign bus.data_valid   = pop && req_id_e'(head) == REQ_DATA;
    assign bus.instr_err    = bus.instr_valid && bus.mem_err;
    assign bus.data_error   = bus.data_valid && bus.mem_err;
    assign bus.instr_rdata  = en ? bus.mem_rdata : '0;
    assign bus.data_rdata   = en ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a round-robin DUT (b1) and a fixed-priority DUT (b0) share stimulus;
// grants push expected owners to a queue that responses pop and check.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sbq[$];

    mem_bus_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) b0 ();

    mem_bus_arbiter #(.MAX_OUTST(2), .ARB_MODE(ARB_RR), .AW(32), .DW(32)) u_rr (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave));
    mem_bus_arbiter #(.MAX_OUTST(2), .ARB_MODE(ARB_FIXED), .AW(32), .DW(32)) u_fix (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave));

    assign b0.instr_req  = b1.instr_req;
    assign b0.instr_addr = b1.instr_addr;
    assign b0.data_req   = b1.data_req;
    assign b0.data_wr    = b1.data_wr;
    assign b0.data_addr  = b1.data_addr;
    assign b0.data_wdata = b1.data_wdata;
    assign b0.data_be    = b1.data_be;
    assign b0.mem_gnt    = b1.mem_gnt;
    assign b0.mem_rdata  = b1.mem_rdata;
    assign b0.mem_valid  = b1.mem_valid;
    assign b0.mem_err    = b1.mem_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        b1.instr_req  = 1'b0;
        b1.data_req   = 1'b0;
        b1.data_wr    = 1'b0;
        b1.mem_gnt    = 1'b0;
        b1.mem_valid  = 1'b0;
        b1.mem_err    = 1'b0;
        b1.mem_rdata  = '0;
    endtask

    task automatic rsp(input logic [31:0] d, input logic e);
        b1.mem_valid = 1'b1;
        b1.mem_rdata = d;
        b1.mem_err   = e;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant check; an accepted transfer records its expected owner.
    task automatic chk_gnt(input string tag, input bit acc, input bit id);
        chk({tag, ".igt"}, 32'(b1.instr_gnt), 32'(acc && !id));
        chk({tag, ".dgt"}, 32'(b1.data_gnt),  32'(acc && id));
        if (acc) sbq.push_back(id);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] d, input logic e);
        bit id;
        n_cmp++;
        assert (sbq.size() != 0) else begin
            n_err++;
            $error("FAIL %s observed=response expected=no outstanding entry", tag);
        end
        if (sbq.size() != 0) begin
            id = sbq.pop_front();
            chk({tag, ".ival"}, 32'(b1.instr_valid), 32'(!id));
            chk({tag, ".dval"}, 32'(b1.data_valid), 32'(id));
            chk({tag, ".rdata"}, id ? b1.data_rdata : b1.instr_rdata, d);
            chk({tag, ".err"}, 32'(id ? b1.data_error : b1.instr_err), 32'(e));
            chk({tag, ".spur"}, 32'(b1.spurious_rsp), 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        b1.instr_addr = '0; b1.data_addr = '0; b1.data_wdata = '0; b1.data_be = '0;
        idle();
        b1.instr_req = 1'b1; b1.data_req = 1'b1; b1.mem_gnt = 1'b1; b1.mem_valid = 1'b1;
        cyc(); cyc(); settle();
        chk("rst.mem_req", 32'(b1.mem_req), 0);
        chk("rst.igt", 32'(b1.instr_gnt), 0);
        chk("rst.dgt", 32'(b1.data_gnt), 0);
        chk("rst.spur", 32'(b1.spurious_rsp), 0);
        chk("rst.ival", 32'(b1.instr_valid), 0);
        cyc(); reset_n = 1'b1; settle();
        chk("rel.mem_req", 32'(b1.mem_req), 0);
        chk("rel.dgt", 32'(b1.data_gnt), 0);
        cyc(); idle(); settle();
        chk("idle.mem_req", 32'(b1.mem_req), 0);

        // Single fetch
        cyc(); b1.instr_req = 1'b1; b1.instr_addr = 32'h100; b1.mem_gnt = 1'b1; settle();
        chk_gnt("f1", 1'b1, 1'b0);
        chk("f1.addr", b1.mem_addr, 32'h100);
        chk("f1.be", 32'(b1.mem_be), 32'hF);
        chk("f1.wr", 32'(b1.mem_wr), 0);
        cyc(); idle();
        cyc(); rsp(32'h13, 1'b0); settle();
        chk_rsp("f1.rsp", 32'h13, 1'b0);

        // Round-robin contention with interleaved responses
        cyc(); idle(); b1.instr_req = 1'b1; b1.data_req = 1'b1; b1.mem_gnt = 1'b1; settle();
        chk_gnt("rr1", 1'b1, 1'b1);
        cyc(); settle();
        chk_gnt("rr2", 1'b1, 1'b0);
        cyc(); rsp(32'hA, 1'b0); settle();
        chk("rr3.full", 32'(b1.mem_req), 0);
        chk_rsp("rr3.rsp", 32'hA, 1'b0);
        chk_gnt("rr3", 1'b0, 1'b0);
        cyc(); rsp(32'hB, 1'b0); settle();
        chk_rsp("rr4.rsp", 32'hB, 1'b0);
        chk_gnt("rr4", 1'b1, 1'b1);
        cyc(); rsp(32'hC, 1'b0); settle();
        chk_rsp("rr5.rsp", 32'hC, 1'b0);
        chk_gnt("rr5", 1'b1, 1'b0);
        cyc(); b1.instr_req = 1'b0; b1.data_req = 1'b0; rsp(32'hD, 1'b0); settle();
        chk_rsp("rr6.rsp", 32'hD, 1'b0);

        // Fixed-priority contention on b0
        cyc(); idle(); b1.instr_req = 1'b1; b1.data_req = 1'b1; b1.mem_gnt = 1'b1;
        b1.instr_addr = 32'h300; b1.data_addr = 32'h200; b1.data_be = 4'h5;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin cyc(); rsp(32'(k), 1'b0); end
            settle();
            chk("fx.dgt", 32'(b0.data_gnt), 1);
            chk("fx.igt", 32'(b0.instr_gnt), 0);
            chk("fx.be", 32'(b0.mem_be), 32'h5);
            chk("fx.addr", b0.mem_addr, 32'h200);
            if (k > 0) chk("fx.dval", 32'(b0.data_valid), 1);
        end
        cyc(); idle(); rsp(32'h3, 1'b0); settle();
        chk("fx.drain", 32'(b0.data_valid), 1);

        // Stall with lock, then full blocking
        cyc(); idle(); b1.instr_req = 1'b1; b1.instr_addr = 32'h400; settle();
        chk("st1.req", 32'(b1.mem_req), 1);
        chk("st1.addr", b1.mem_addr, 32'h400);
        chk("st1.igt", 32'(b1.instr_gnt), 0);
        for (int k = 0; k < 2; k++) begin
            cyc(); b1.data_req = 1'b1; b1.data_addr = 32'h500; settle();
            chk("st.rr.addr", b1.mem_addr, 32'h400);
            chk("st.fx.addr", b0.mem_addr, 32'h400);
            chk("st.dgt", 32'(b1.data_gnt), 0);
        end
        cyc(); b1.mem_gnt = 1'b1; settle();
        chk_gnt("st4", 1'b1, 1'b0);
        chk("st4.fx.igt", 32'(b0.instr_gnt), 1);
        cyc(); settle();
        chk_gnt("st5", 1'b1, 1'b1);
        cyc(); settle();
        chk("st6.full", 32'(b1.mem_req), 0);
        chk_gnt("st6", 1'b0, 1'b0);
        cyc(); rsp(32'h11, 1'b0); settle();
        chk_rsp("st7.rsp", 32'h11, 1'b0);
        chk("st7.full", 32'(b1.mem_req), 0);
        cyc(); b1.mem_valid = 1'b0; b1.mem_gnt = 1'b0; settle();
        chk("st8.req", 32'(b1.mem_req), 1);
        cyc(); idle(); rsp(32'h22, 1'b0); settle();
        chk_rsp("st9.rsp", 32'h22, 1'b0);

        // Write with error response
        cyc(); idle(); b1.data_req = 1'b1; b1.data_wr = 1'b1; b1.data_be = 4'b0011;
        b1.data_wdata = 32'hDEADBEEF; b1.data_addr = 32'h600; b1.mem_gnt = 1'b1; settle();
        chk_gnt("wr", 1'b1, 1'b1);
        chk("wr.wr", 32'(b1.mem_wr), 1);
        chk("wr.be", 32'(b1.mem_be), 32'h3);
        chk("wr.wdata", b1.mem_wdata, 32'hDEADBEEF);
        chk("wr.addr", b1.mem_addr, 32'h600);
        cyc(); idle(); rsp(32'h0, 1'b1); settle();
        chk_rsp("wr.rsp", 32'h0, 1'b1);

        // Reset with two transactions in flight
        cyc(); idle(); b1.instr_req = 1'b1; b1.mem_gnt = 1'b1; settle();
        chk("rm1.igt", 32'(b1.instr_gnt), 1);
        cyc(); b1.instr_req = 1'b0; b1.data_req = 1'b1; settle();
        chk("rm2.dgt", 32'(b1.data_gnt), 1);
        cyc(); idle(); reset_n = 1'b0;
        cyc(); reset_n = 1'b1;
        cyc();
        cyc(); rsp(32'h33, 1'b0); settle();
        chk("rm.spur", 32'(b1.spurious_rsp), 1);
        chk("rm.ival", 32'(b1.instr_valid), 0);
        chk("rm.dval", 32'(b1.data_valid), 0);
        cyc(); idle(); settle();
        chk("rm.spur_end", 32'(b1.spurious_rsp), 0);
        cyc(); b1.instr_req = 1'b1; b1.mem_gnt = 1'b1; settle();
        chk_gnt("rm.f", 1'b1, 1'b0);
        cyc(); idle(); rsp(32'h44, 1'b0); settle();
        chk_rsp("rm.rsp", 32'h44, 1'b0);
        cyc(); rsp(32'h55, 1'b0); settle();
        chk("rm.empty", 32'(b1.spurious_rsp), 1);
        cyc(); idle();
        chk("sb.empty", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
